// File: rtl/ase_idle_pkg.sv
// Shared types and width helper for the ASE idle tracker.
package ase_idle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_QUIET = 2'd2
  } idle_state_e;

  // Bits needed to hold values 0..n inclusive (at least 1).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ase_idle_tracker_if.sv
// Channel-monitor / reset-driver side bundle for the idle tracker.
interface ase_idle_tracker_if
  import ase_idle_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 1024
);
  localparam int unsigned CNT_W = cnt_w(MAX_OUTSTANDING);

  logic             rd_req_valid;
  logic             wr_req_valid;
  logic             rd_rsp_valid;
  logic             wr_rsp_valid;
  logic             reset_lockdown;
  logic             req_block;
  logic             system_is_idle;
  logic [CNT_W-1:0] rd_outstanding;
  logic [CNT_W-1:0] wr_outstanding;
  logic             underflow_err;
  logic             blocked_req_err;
  logic             timeout_err;

  modport master (
    output rd_req_valid, wr_req_valid, rd_rsp_valid, wr_rsp_valid, reset_lockdown,
    input  req_block, system_is_idle, rd_outstanding, wr_outstanding,
    input  underflow_err, blocked_req_err, timeout_err
  );

  modport slave (
    input  rd_req_valid, wr_req_valid, rd_rsp_valid, wr_rsp_valid, reset_lockdown,
    output req_block, system_is_idle, rd_outstanding, wr_outstanding,
    output underflow_err, blocked_req_err, timeout_err
  );

endinterface

// File: rtl/ase_outstanding_ctr.sv
// Per-channel outstanding transaction counter, saturating at 0 and MAX_OUTSTANDING.
module ase_outstanding_ctr
  import ase_idle_pkg::*;
#(
  parameter  int unsigned MAX_OUTSTANDING = 1024,
  localparam int unsigned CNT_W           = cnt_w(MAX_OUTSTANDING)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_req,
  input  logic             rsp,
  output logic [CNT_W-1:0] count,
  output logic             at_max,
  output logic             is_zero_next,
  output logic             underflow
);

  logic [CNT_W-1:0] count_next;

  assign at_max = (count == CNT_W'(MAX_OUTSTANDING));

  // Next count; a response with nothing outstanding is flagged and ignored.
  always_comb begin
    count_next = count;
    underflow  = 1'b0;
    if (acc_req && !rsp) begin
      if (!at_max) count_next = count + CNT_W'(1);
    end else if (rsp && !acc_req) begin
      if (count == '0) underflow  = 1'b1;
      else             count_next = count - CNT_W'(1);
    end
  end

  assign is_zero_next = (count_next == '0);

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_next;
  end

endmodule

// File: rtl/ase_idle_tracker.sv
// Outstanding-transaction tracker producing the ASE quiescence flag and request backpressure.
module ase_idle_tracker
  import ase_idle_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 1024,
  parameter int unsigned QUIET_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 65536
) (
  input  logic             clk,
  input  logic             ase_reset,
  ase_idle_tracker_if.slave bus
);

  localparam int unsigned QW         = cnt_w(QUIET_CYCLES);
  localparam int unsigned TW         = cnt_w(TIMEOUT_CYCLES);
  localparam int unsigned QUIET_LOAD = (QUIET_CYCLES > 0) ? (QUIET_CYCLES - 1) : 0;

  idle_state_e   state, state_next;
  logic [QW-1:0] quiet_cnt, quiet_next;
  logic [TW-1:0] wd_cnt, wd_next;

  logic rd_at_max, wr_at_max;
  logic rd_zero_next, wr_zero_next;
  logic rd_underflow, wr_underflow;
  logic block, rd_acc, wr_acc, any_acc, any_rsp;

  // Backpressure is combinational so a same-cycle lockdown still stops the request.
  assign block          = bus.reset_lockdown | rd_at_max | wr_at_max;
  assign bus.req_block  = block;
  assign rd_acc         = bus.rd_req_valid & ~block;
  assign wr_acc         = bus.wr_req_valid & ~block;
  assign any_acc        = rd_acc | wr_acc;
  assign any_rsp        = bus.rd_rsp_valid | bus.wr_rsp_valid;

  ase_outstanding_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_rd_ctr (
    .clk          (clk),
    .rst          (ase_reset),
    .acc_req      (rd_acc),
    .rsp          (bus.rd_rsp_valid),
    .count        (bus.rd_outstanding),
    .at_max       (rd_at_max),
    .is_zero_next (rd_zero_next),
    .underflow    (rd_underflow)
  );

  ase_outstanding_ctr #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_wr_ctr (
    .clk          (clk),
    .rst          (ase_reset),
    .acc_req      (wr_acc),
    .rsp          (bus.wr_rsp_valid),
    .count        (bus.wr_outstanding),
    .at_max       (wr_at_max),
    .is_zero_next (wr_zero_next),
    .underflow    (wr_underflow)
  );

  // Next state and quiet-window countdown.
  always_comb begin
    state_next = state;
    quiet_next = quiet_cnt;
    case (state)
      ST_IDLE: begin
        if (any_acc) state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (rd_zero_next && wr_zero_next) begin
          if (QUIET_CYCLES == 0) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_QUIET;
            quiet_next = QW'(QUIET_LOAD);
          end
        end
      end
      ST_QUIET: begin
        if (any_acc)                state_next = ST_BUSY;
        else if (quiet_cnt == '0)   state_next = ST_IDLE;
        else                        quiet_next = quiet_cnt - QW'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Watchdog: counts busy cycles without a response, restarting on entry and saturating at the limit.
  always_comb begin
    wd_next = wd_cnt;
    if (state != ST_BUSY || state_next != ST_BUSY || any_rsp) wd_next = '0;
    else if (wd_cnt != TW'(TIMEOUT_CYCLES))                  wd_next = wd_cnt + TW'(1);
  end

  // State, counters, idle flag and sticky errors.
  always_ff @(posedge clk or posedge ase_reset) begin
    if (ase_reset) begin
      state               <= ST_IDLE;
      quiet_cnt           <= '0;
      wd_cnt              <= '0;
      bus.system_is_idle  <= 1'b1;
      bus.underflow_err   <= 1'b0;
      bus.blocked_req_err <= 1'b0;
      bus.timeout_err     <= 1'b0;
    end else begin
      state               <= state_next;
      quiet_cnt           <= quiet_next;
      wd_cnt              <= wd_next;
      bus.system_is_idle  <= (state_next == ST_IDLE);
      if (rd_underflow || wr_underflow)
        bus.underflow_err <= 1'b1;
      if ((bus.rd_req_valid || bus.wr_req_valid) && block)
        bus.blocked_req_err <= 1'b1;
      if (state == ST_BUSY && wd_next == TW'(TIMEOUT_CYCLES))
        bus.timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/ase_idle_tracker.md
# ase_idle_tracker

Tracks outstanding read and write transactions between the emulated host channel and the AFU and produces `system_is_idle` for the ASE simulation driver, which holds system and soft reset until the design is quiescent. Also takes the driver's `reset_lockdown` and turns it into request backpressure so no new work starts while a reset is pending. Sits inside the protocol-specific parent module, between the channel monitors and the ASE reset/dealloc logic.

## Interface
- `MAX_OUTSTANDING`, 1024: per-channel outstanding limit; counter width `CNT_W = $clog2(MAX_OUTSTANDING+1)`.
- `QUIET_CYCLES`, 16: cycles with zero outstanding required before idle is declared; 0 is legal.
- `TIMEOUT_CYCLES`, 65536: busy cycles without any response before `timeout_err` is set.
- `clk`  in  1  primary simulation clock; everything is on its rising edge.
- `ase_reset`  in  1  system reset, asynchronous, active-high.
- `rd_req_valid`  in  1  read request presented this cycle.
- `wr_req_valid`  in  1  write request presented this cycle.
- `rd_rsp_valid`  in  1  one read response returned this cycle.
- `wr_rsp_valid`  in  1  one write response returned this cycle.
- `reset_lockdown`  in  1  driver has a reset pending.
- `req_block`  out  1  combinational backpressure; a request is accepted only when `*_req_valid && !req_block`.
- `system_is_idle`  out  1  registered quiescence flag.
- `rd_outstanding`, `wr_outstanding`  out  CNT_W  current counts.
- `underflow_err`, `blocked_req_err`, `timeout_err`  out  1  sticky error flags, cleared only by `ase_reset`.

## Operation
- Counters: `next = cur + acc_req - rsp`. Simultaneous accepted request and response leaves the count unchanged.
- A response arriving at count 0 with no accepted request in the same cycle: the count stays 0 and `underflow_err` is set.
- `req_block = reset_lockdown | (rd_outstanding == MAX_OUTSTANDING) | (wr_outstanding == MAX_OUTSTANDING)`. It blocks both channels.
- Any `*_req_valid` while `req_block` is high is dropped, not counted, and sets `blocked_req_err`.
- FSM states:
  - ST_IDLE: `system_is_idle = 1`. Any accepted request moves to ST_BUSY.
  - ST_BUSY: when both next counts are 0, go to ST_QUIET and load `quiet_cnt = QUIET_CYCLES-1`. If `QUIET_CYCLES == 0`, go directly to ST_IDLE.
  - ST_QUIET: an accepted request returns to ST_BUSY. Otherwise, at `quiet_cnt == 0` go to ST_IDLE; else decrement `quiet_cnt`.
  - A stray response (underflow) in ST_QUIET or ST_IDLE does not change state.
- `system_is_idle` is 1 only in ST_IDLE.
- Watchdog: runs only in ST_BUSY. It clears on any response or state entry and increments otherwise. When it reaches `TIMEOUT_CYCLES`, `timeout_err` is set; the watchdog saturates and the state is unchanged.

## Timing
- Reset values: ST_IDLE, `system_is_idle = 1`, counts 0, all error flags 0, `quiet_cnt` 0, watchdog 0. `req_block` follows `reset_lockdown`.
- `system_is_idle` must reset to 1 so that the driver's initial reset wait does not deadlock.
- Request accepted in cycle N: the count updates and `system_is_idle` falls at edge N+1.
- Last response in cycle M (counts reach 0): `system_is_idle` rises at edge M+1+QUIET_CYCLES.
- `ase_reset` asserted mid-operation immediately clears counts, state and flags asynchronously. It takes no account of transactions in flight.
- `reset_lockdown` rising in the same cycle as a request: the request is blocked (the path is combinational).
- Counts never exceed `MAX_OUTSTANDING` and never go below 0.

## Structure
- Shared package `ase_idle_pkg`: `idle_state_e` enum (ST_IDLE, ST_BUSY, ST_QUIET) and the `cnt_w()` width function.
- Sub-module `ase_outstanding_ctr`, instantiated twice (read, write). Inputs: `acc_req`, `rsp`. Outputs: count, `at_max`, `is_zero_next`, `underflow` pulse.
- The FSM, watchdog and error flags live in the top module.

## Test plan
- Reset release, no traffic → `system_is_idle = 1`, counts 0, all errors 0 and held indefinitely.
- With `QUIET_CYCLES = 16`: 3 read requests in cycles 0–2, responses in cycles 10–12 → idle falls at edge 1 and rises at edge 29. `rd_outstanding` peaks at 3.
- Request and response together at count 1 → count stays 1. A new request during ST_QUIET (cycle 5 of 16) → returns to ST_BUSY and the quiet window restarts.
- With `MAX_OUTSTANDING = 4`: 5 back-to-back write requests → `req_block` high once the count is 4, 5th request dropped, `blocked_req_err = 1`, count stays 4.
- Write response at count 0 → `underflow_err = 1`, count 0, state ST_IDLE. Then `reset_lockdown = 1` → `req_block = 1` in the same cycle.
- With `TIMEOUT_CYCLES = 100`: one read with no response → `timeout_err = 1` after 100 busy cycles. Then `ase_reset` pulse mid-operation → all outputs return to their reset values.
